pipeline_skid_stage: RTL and testbench

PIPELINE_SKID_STAGE -- requirements
Module: pipeline_skid_stage

---
 rtl/pipeline_skid_stage_pkg.sv | 22 ++
 rtl/pipeline_skid_stage.sv | 103 ++++++++++
 tb/tb_pipeline_skid_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipeline_skid_stage_pkg.sv
// Shared widths, constants and state encoding for the skid-buffer stage.
// State is the pair {main_valid, skid_valid}; no separate state register.
package pipeline_skid_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] PIPE_BUBBLE = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } skid_state_e;

  function automatic logic [1:0] occ(
    input logic main_v,
    input logic skid_v
  );
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipeline_skid_stage.sv
// Two-entry skid buffer stage: registered valid/ready on both sides,
// order-preserving, with synchronous flush and asynchronous reset.
module pipeline_skid_stage
  import pipeline_skid_stage_pkg::*;
#(
  parameter int              DATA_W     = XLEN,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic              rdy_q, rdy_d;
  logic [1:0]        cnt_q, cnt_d;

  skid_state_e state;
  logic        push;
  logic        pop;

  assign state = skid_state_e'({main_vld_q, skid_vld_q});
  assign push  = i_valid & rdy_q;
  assign pop   = main_vld_q & i_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (i_flush) begin
      main_d     = BUBBLE_VAL;
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (push) begin
            main_d     = i_data;
            main_vld_d = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = i_data;
          end else if (push) begin
            skid_d     = i_data;
            skid_vld_d = 1'b1;
          end else if (pop) begin
            main_vld_d = 1'b0;
          end
        end
        ST_TWO: begin
          // o_ready is low here, so only a pop can move the state
          if (pop) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
          end
        end
        default: begin
          main_vld_d = 1'b0;
          skid_vld_d = 1'b0;
        end
      endcase
    end
    rdy_d = ~skid_vld_d;
    cnt_d = occ(main_vld_d, skid_vld_d);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      main_q     <= BUBBLE_VAL;
      skid_q     <= BUBBLE_VAL;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
      cnt_q      <= 2'd0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_ready = rdy_q;
  assign o_valid = main_vld_q;
  assign o_data  = main_q;
  assign o_count = cnt_q;

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Directed and randomized checks of pipeline_skid_stage against a
// queue-based model of a two-entry in-order buffer.
module tb_pipeline_skid_stage;
  import pipeline_skid_stage_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] BUB = PIPE_BUBBLE;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         vld_in = 1'b0;
  logic         rdy_out;
  logic [W-1:0] din = '0;
  logic         vld_out;
  logic         rdy_in = 1'b0;
  logic [W-1:0] dout;
  logic [1:0]   cnt;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] last = BUB;

  pipeline_skid_stage #(
    .DATA_W    (W),
    .BUBBLE_VAL(BUB)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_flush(flush),
    .i_valid(vld_in),
    .o_ready(rdy_out),
    .i_data (din),
    .o_valid(vld_out),
    .i_ready(rdy_in),
    .o_data (dout),
    .o_count(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, {31'b0, vld_out}, {31'b0, q.size() > 0});
    chk({tag, ".ready"}, {31'b0, rdy_out}, {31'b0, q.size() < 2});
    chk({tag, ".count"}, {30'b0, cnt}, 32'(q.size()));
    chk({tag, ".data"}, dout, last);
  endtask

  task automatic model_reset();
    q.delete();
    last = BUB;
  endtask

  task automatic step(input logic v, input logic [W-1:0] d,
                      input logic r, input logic f, input string tag);
    logic         stalled;
    logic [W-1:0] held;
    logic         push;
    logic         pop;
    vld_in  = v;
    din     = d;
    rdy_in  = r;
    flush   = f;
    stalled = (q.size() > 0) && !r && !f;
    held    = dout;
    push    = v && (q.size() < 2);
    pop     = (q.size() > 0) && r;
    @(posedge clk);
    if (f) begin
      model_reset();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      if (q.size() > 0) last = q[0];
    end
    #1;
    chk_model(tag);
    if (stalled) chk({tag, ".stall"}, dout, held);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk_model("reset");
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // stream 0x11..0x18 with downstream always ready
    step(1'b1, 32'h11, 1'b1, 1'b0, "s0");
    chk("s0.lit", dout, 32'h11);
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 32'h11 + W'(i), 1'b1, 1'b0, "stream");
      chk("stream.lit", dout, 32'h11 + W'(i));
    end
    step(1'b0, '0, 1'b1, 1'b0, "drain");
    chk("drain.vld", {31'b0, vld_out}, 32'd0);

    // backpressure
    step(1'b1, 32'h21, 1'b0, 1'b0, "bp0");
    step(1'b1, 32'h22, 1'b0, 1'b0, "bp1");
    chk("bp.cnt", {30'b0, cnt}, 32'd2);
    chk("bp.data", dout, 32'h21);
    step(1'b1, 32'h23, 1'b0, 1'b0, "bp2");
    step(1'b0, '0, 1'b1, 1'b0, "bp3");
    chk("bp3.lit", dout, 32'h22);
    step(1'b0, '0, 1'b1, 1'b0, "bp4");
    chk("bp4.vld", {31'b0, vld_out}, 32'd0);

    // flush in TWO drops the concurrent push
    step(1'b1, 32'h31, 1'b0, 1'b0, "fl0");
    step(1'b1, 32'h32, 1'b0, 1'b0, "fl1");
    step(1'b1, 32'h33, 1'b0, 1'b1, "fl2");
    chk("fl.data", dout, BUB);
    step(1'b0, '0, 1'b1, 1'b0, "fl3");
    chk("fl3.vld", {31'b0, vld_out}, 32'd0);

    // simultaneous push and pop in ONE
    step(1'b1, 32'h41, 1'b1, 1'b0, "pp0");
    step(1'b1, 32'h42, 1'b1, 1'b0, "pp1");
    chk("pp.lit", dout, 32'h42);
    chk("pp.cnt", {30'b0, cnt}, 32'd1);
    step(1'b0, '0, 1'b1, 1'b0, "pp2");

    // asynchronous reset between edges while in TWO
    step(1'b1, 32'h4a, 1'b0, 1'b0, "ar0");
    step(1'b1, 32'h4b, 1'b0, 1'b0, "ar1");
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk_model("arst");
    #1 rst = 1'b0;
    step(1'b1, 32'h51, 1'b1, 1'b0, "ar2");
    chk("ar2.lit", dout, 32'h51);

    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom), $urandom, 1'($urandom),
           $urandom_range(0, 31) == 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
